// File: rtl/systolic_fp_pkg.sv
// Shared types and constants for the systolic array FP drain path.
// The BF16_SATURATE_EN macro (used by fp32_to_bf16_rne) selects saturation
// instead of overflow-to-Inf for finite values that round past max finite.
package systolic_fp_pkg;

  typedef logic [31:0] fp32_t;
  typedef logic [15:0] bf16_t;

  // Magnitude encodings (sign bit is prepended by the user).
  localparam logic [14:0] BF16_QNAN = 15'h7FC0;
  localparam logic [14:0] BF16_INF  = 15'h7F80;
  localparam logic [14:0] BF16_MAXF = 15'h7F7F;
  localparam logic [31:0] RNE_BIAS  = 32'h7FFF;

  // Halfword packer state: EMPTY has no pending low half, HALF holds one.
  typedef enum logic [0:0] {
    PK_EMPTY = 1'b0,
    PK_HALF  = 1'b1
  } pk_state_e;

  // True when the FP32 value encodes a NaN.
  function automatic logic fp32_is_nan(input fp32_t x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

endpackage

// File: rtl/fp32_to_bf16_rne.sv
// Combinational FP32 -> BF16 narrowing with fast round-to-nearest-even.
// NaN -> quiet NaN, zero/subnormal -> signed zero, Inf passes through.
// Macro BF16_SATURATE_EN: finite values rounding into exp 8'hFF give
// +/- max finite instead of +/- Inf.
module fp32_to_bf16_rne
  import systolic_fp_pkg::*;
(
  input  fp32_t x,
  output bf16_t y
);

  logic  sign_s;
  logic  [7:0] exp_s;
  bf16_t rnd_s;

  assign sign_s = x[31];
  assign exp_s  = x[30:23];
  // Bias of 0x7FFF plus the kept lsb rounds ties toward the even result.
  assign rnd_s  = bf16_t'((x + RNE_BIAS + {31'h0, x[16]}) >> 16);

  // Special-case selection in priority order, then rounded value.
  always_comb begin
    y = rnd_s;
    if (fp32_is_nan(x)) begin
      y = {sign_s, BF16_QNAN};
    end else if (exp_s == 8'h00) begin
      y = {sign_s, 15'h0000};
    end else if (exp_s == 8'hFF) begin
      y = {sign_s, BF16_INF};
    end else if (rnd_s[14:7] == 8'hFF) begin
`ifdef BF16_SATURATE_EN
      y = {sign_s, BF16_MAXF};
`else
      y = {sign_s, BF16_INF};
`endif
    end else begin
      y = rnd_s;
    end
  end

endmodule

// File: rtl/fp32_to_bf16_packer.sv
// Streaming FP32 -> BF16 narrowing and two-per-word packer.
// Stage S1 holds one rounded element; the output register holds one word.
// Rounding behaviour on overflow follows the BF16_SATURATE_EN macro inside
// fp32_to_bf16_rne.
module fp32_to_bf16_packer
  import systolic_fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_keep
);

  bf16_t       rne_y_s;
  logic        ready_en_r;
  logic        s1_valid_r;
  logic        s1_last_r;
  bf16_t       s1_data_r;
  bf16_t       low_r;
  pk_state_e   state_r;
  pk_state_e   state_nxt_s;
  logic        out_valid_r;
  logic [31:0] out_data_r;
  logic [1:0]  out_keep_r;
  logic        out_space_s;
  logic        s1_adv_s;
  logic        low_load_s;
  logic        word_load_s;
  logic [31:0] word_data_s;
  logic [1:0]  word_keep_s;
  logic        accept_s;

  fp32_to_bf16_rne u_rne (
    .x (in_data),
    .y (rne_y_s)
  );

  // Output register can take a word if empty or being drained this edge.
  assign out_space_s = !out_valid_r || out_ready;
  assign in_ready    = ready_en_r && (!s1_valid_r || s1_adv_s);
  assign accept_s    = in_valid && in_ready;

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_keep  = out_keep_r;

  // Hold in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // S1: rounded element, its last flag and valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_data_r  <= 16'h0000;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_last_r  <= in_last;
      s1_data_r  <= rne_y_s;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Packer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= PK_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Packer next state, S1 advance and word formation.
  always_comb begin
    state_nxt_s = state_r;
    s1_adv_s    = 1'b0;
    low_load_s  = 1'b0;
    word_load_s = 1'b0;
    word_data_s = 32'h0000_0000;
    word_keep_s = 2'b00;
    case (state_r)
      PK_EMPTY: begin
        if (s1_valid_r && !s1_last_r) begin
          low_load_s  = 1'b1;
          s1_adv_s    = 1'b1;
          state_nxt_s = PK_HALF;
        end else if (s1_valid_r && s1_last_r && out_space_s) begin
          // Flush a lone element as a single-halfword word.
          word_load_s = 1'b1;
          word_data_s = {16'h0000, s1_data_r};
          word_keep_s = 2'b01;
          s1_adv_s    = 1'b1;
        end else begin
          state_nxt_s = PK_EMPTY;
        end
      end
      PK_HALF: begin
        if (s1_valid_r && out_space_s) begin
          // Completing element; in_last has no further effect here.
          word_load_s = 1'b1;
          word_data_s = {s1_data_r, low_r};
          word_keep_s = 2'b11;
          s1_adv_s    = 1'b1;
          state_nxt_s = PK_EMPTY;
        end else begin
          state_nxt_s = PK_HALF;
        end
      end
      default: begin
        state_nxt_s = PK_EMPTY;
      end
    endcase
  end

  // Pending low halfword while in HALF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_r <= 16'h0000;
    end else if (low_load_s) begin
      low_r <= s1_data_r;
    end
  end

  // Output word register; contents hold steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 32'h0000_0000;
      out_keep_r  <= 2'b00;
    end else if (word_load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= word_data_s;
      out_keep_r  <= word_keep_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp32_to_bf16_packer.sv
// Self-checking bench for fp32_to_bf16_packer: directed vectors with literal
// expectations plus a scoreboard fed by a behavioural rounding/pairing model.
module tb_fp32_to_bf16_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_keep;

  int errors = 0;
  int checks = 0;
  int words_seen = 0;

  logic [33:0] exp_q[$];
  logic        p_have = 1'b0;
  logic [15:0] p_lo = 16'h0000;
  logic        held_v = 1'b0;
  logic [33:0] held_w = 34'h0;

  fp32_to_bf16_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural BF16 conversion: compare the discarded half against 0x8000.
  function automatic logic [15:0] model_bf16(input logic [31:0] x);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [15:0] hi;
    logic [15:0] lo;
    s = x[31]; e = x[30:23]; m = x[22:0];
    hi = x[31:16]; lo = x[15:0];
    if (e == 8'd255 && m != 23'd0) return {s, 15'h7FC0};
    if (e == 8'd0) return {s, 15'h0000};
    if (e == 8'd255) return {s, 15'h7F80};
    if (lo > 16'h8000 || (lo == 16'h8000 && hi[0])) hi = hi + 16'd1;
    if (hi[14:7] == 8'hFF) begin
`ifdef BF16_SATURATE_EN
      return {s, 15'h7F7F};
`else
      return {s, 15'h7F80};
`endif
    end
    return hi;
  endfunction

  // Pairing model: earlier element low, later high; last flushes a single.
  task automatic model_accept(input logic [31:0] d, input logic l);
    logic [15:0] v;
    v = model_bf16(d);
    if (p_have) begin
      exp_q.push_back({2'b11, v, p_lo});
      p_have = 1'b0;
    end else if (l) begin
      exp_q.push_back({2'b01, 16'h0000, v});
    end else begin
      p_have = 1'b1;
      p_lo = v;
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      p_have = 1'b0;
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", {33'h0, out_valid}, 34'h1);
        chk("stall_stable", {out_keep, out_data}, held_w);
      end
      if (out_valid && out_ready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h, expected no word", {out_keep, out_data});
        end else begin
          chk("scoreboard_word", {out_keep, out_data}, exp_q.pop_front());
        end
      end
      held_v = out_valid && !out_ready;
      held_w = {out_keep, out_data};
      if (in_valid && in_ready) model_accept(in_data, in_last);
    end
  end

  // Offer one element; returns just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for the next output word and compare with a literal.
  task automatic wait_word(input string name, input logic [31:0] d, input logic [1:0] k);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, {out_keep, out_data}, {k, d});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 32'h0;
    in_last = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", {33'h0, in_ready}, 34'h0);
    chk("rst_out_valid", {33'h0, out_valid}, 34'h0);
    chk("rst_out_word", {out_keep, out_data}, 34'h0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("release_in_ready_low", {33'h0, in_ready}, 34'h0);
    @(posedge clk);
    #1;
    chk("after_release_in_ready", {33'h0, in_ready}, 34'h1);

    // RNE ties, each padded with a zero element.
    send(32'h3F808000, 1'b0); send(32'h0000_0000, 1'b0);
    wait_word("tie_even_down", 32'h0000_3F80, 2'b11);
    send(32'h3F818000, 1'b0); send(32'h0000_0000, 1'b0);
    wait_word("tie_odd_up", 32'h0000_3F82, 2'b11);
    send(32'h3F80C000, 1'b0); send(32'h0000_0000, 1'b0);
    wait_word("above_half", 32'h0000_3F81, 2'b11);

    // Pairing with latency check.
    send(32'h3F800000, 1'b0); send(32'h40000000, 1'b0);
    @(negedge clk);
    chk("pair_lat_t0", {33'h0, out_valid}, 34'h0);
    @(negedge clk);
    chk("pair_lat_t1", {33'h0, out_valid}, 34'h1);
    chk("pair_word", {out_keep, out_data}, {2'b11, 32'h40003F80});
    @(posedge clk); #1;

    // Specials.
    send(32'hFFC00001, 1'b0); send(32'h00400000, 1'b0);
    wait_word("nan_subnormal", 32'h0000_FFC0, 2'b11);
    send(32'h7F7FFFFF, 1'b0); send(32'hFF800000, 1'b0);
`ifdef BF16_SATURATE_EN
    wait_word("overflow_ninf", 32'hFF80_7F7F, 2'b11);
`else
    wait_word("overflow_ninf", 32'hFF80_7F80, 2'b11);
`endif

    // Flush then a fresh pair to show the packer is back in EMPTY.
    send(32'hBF800000, 1'b1);
    wait_word("flush_single", 32'h0000_BF80, 2'b01);
    send(32'h3F800000, 1'b0); send(32'h40000000, 1'b0);
    wait_word("pair_after_flush", 32'h40003F80, 2'b11);

    // Back-to-back throughput through the scoreboard.
    for (int i = 0; i < 8; i++) send(32'h3F800000 + (i << 20) + (i << 14), i == 7);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: 6 elements, out_ready low for 10 cycles.
    seen0 = words_seen;
    out_ready = 1'b0;
    fork
      begin
        send(32'h3F800000, 1'b0); send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0); send(32'h40800000, 1'b0);
        send(32'h40A00000, 1'b0); send(32'h40C00000, 1'b0);
      end
      begin
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", {33'h0, in_ready}, 34'h0);
        chk("bp_held_word", {out_keep, out_data}, {2'b11, 32'h40003F80});
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("bp_word_count", 34'(words_seen - seen0), 34'd3);

    // Reset mid-operation: HALF pending and a full output register.
    out_ready = 1'b0;
    send(32'h41000000, 1'b0); send(32'h41100000, 1'b0); send(32'h41200000, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("pre_reset_out_valid", {33'h0, out_valid}, 34'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {33'h0, out_valid}, 34'h0);
    chk("midrst_in_ready", {33'h0, in_ready}, 34'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h3F800000, 1'b0); send(32'h40000000, 1'b0);
    wait_word("post_reset_word", 32'h40003F80, 2'b11);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 34'(exp_q.size()), 34'd0);
    chk("no_pending_half", {33'h0, p_have}, 34'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp32_to_bf16_packer.md
# fp32_to_bf16_packer

Streaming narrowing unit on the systolic array's drain path. FP32 accumulator results come out of the BF16 multiply/accumulate chain, are rounded to BF16 with fast round-to-nearest-even, and are packed two per 32-bit word for write-back. Valid/ready on both sides, two register stages, no data loss under backpressure.

## Interface
Parameters:
- none. Widths are fixed: FP32 in, 32-bit packed BF16 out.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  unit accepts in_data this cycle
- in_data  input  32  FP32 accumulator value
- in_last  input  1  final element of a drain burst; flushes a partial word
- out_valid  output  1  out_data/out_keep valid
- out_ready  input  1  downstream accepts the word
- out_data  output  32  [15:0] = earlier element, [31:16] = later element
- out_keep  output  2  halfword valid mask: 2'b11 full word, 2'b01 flushed single

## Operation
- Transfer occurs when valid && ready on the same rising edge.
- Rounding (fast RNE): lsb = x[16]; y = (x + 32'h7FFF + lsb) >> 16, 32-bit add, carry discarded.
- Special cases, in priority order:
  - NaN (exp = 8'hFF, mant != 0): output {sign, 15'h7FC0}.
  - Zero/subnormal input (exp = 0): output {sign, 15'h0}. Flush-to-zero, consistent with the multiplier.
  - ±Inf: passes unchanged, 16'h7F80 / 16'hFF80.
  - Rounding carry into exp = 8'hFF gives ±Inf. Changed by the macro; see Configuration.
- S1 register holds the rounded BF16 value, its in_last flag and a valid bit.
- The packer has two halfword states:
  - EMPTY:
    - an S1 element without last goes to the low half; next state HALF.
    - an S1 element with last loads the output word {16'h0, v}, keep 2'b01; state stays EMPTY.
  - HALF:
    - the next S1 element completes the word {v, low}, keep 2'b11; next state EMPTY.
    - in_last on that element changes nothing beyond this.
- Output register holds one word. An element that completes a word may leave S1 only if the output register is empty or is being drained this cycle.
- Element order is preserved exactly; no element is dropped or duplicated.

## Timing
- Reset values: in_ready = 0 during reset, 1 from the first cycle after release; out_valid = 0; out_data = 0; out_keep = 0; packer state EMPTY; S1 invalid.
- Reset mid-operation discards all held data, including a HALF halfword.
- Latency: element accepted at edge t reaches S1 at t. The word it completes is out_valid after edge t+1, i.e. 2 cycles.
- Throughput: one element per cycle sustained while out_ready = 1.
- in_ready = !s1_valid || s1_advances. This is combinational from out_ready, with no path from in_valid.
- out_valid/out_data/out_keep are stable while out_valid && !out_ready.
- Simultaneous drain of the output register and load of a new word on the same edge is legal and loses no bubble cycle.
- in_last while the packer is in HALF with the output register full: stalls in S1 like any other completing element.

## Configuration
- BF16_SATURATE_EN defined: finite inputs that round to exp 8'hFF give ±max finite, 16'h7F7F / 16'hFF7F. True ±Inf and NaN inputs are unaffected.
- BF16_SATURATE_EN undefined: such inputs give ±Inf, 16'h7F80 / 16'hFF80.

## Structure
- Shared package systolic_fp_pkg holds:
  - typedefs fp32_t, bf16_t;
  - constants BF16_QNAN = 15'h7FC0, BF16_INF = 15'h7F80, BF16_MAXF = 15'h7F7F, RNE_BIAS = 32'h7FFF;
  - the packer state enum {PK_EMPTY, PK_HALF}.
- Sub-module fp32_to_bf16_rne holds the purely combinational rounding and special-case logic, including the macro. It is instantiated ahead of S1 and is reusable by other drain paths.

## Test plan
- RNE ties: inputs 32'h3F808000, 32'h3F818000, 32'h3F80C000, each followed by a pad element. Required halfwords: 16'h3F80, 16'h3F82, 16'h3F81.
- Pairing: inputs 32'h3F800000 then 32'h40000000. Required: out_data = 32'h40003F80, out_keep = 2'b11, out_valid 2 cycles after the second accept.
- Specials: inputs 32'hFFC00001, 32'h00400000, 32'h7F7FFFFF, 32'hFF800000. Required halfwords: 16'hFFC0, 16'h0000, then 16'h7F80 (16'h7F7F with BF16_SATURATE_EN), then 16'hFF80.
- Flush: single element 32'hBF800000 with in_last=1. Required: out_data = 32'h0000BF80, out_keep = 2'b01, packer returns to EMPTY.
- Backpressure: out_ready held low for 10 cycles while 6 elements are offered. Required: in_ready deasserts after the pipeline fills, out_data is stable while stalled, all 3 words emerge in order once out_ready rises.
- Reset mid-op: assert rst_n=0 while the packer is in HALF with out_valid=1. Required: out_valid=0 immediately, and after release the first word contains only post-reset elements.
